// File: rtl/demux1x4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux1x4_tdm
// Purpose  : Receive end of a 4-slot TDM link. A 2-bit slot counter locks to
//            a frame-sync marker. One word per slot is captured into a shadow
//            bank, and all four channels are published together once a
//            complete, in-order frame has arrived.
// Ports    : clk          - sole clock, rising edge
//            rst_n        - asynchronous assert, active-low reset
//            din[W]       - slot data word from the link
//            din_valid    - beat qualifier for din and fsync
//            fsync        - marks the current beat as slot 0
//            y0..y3[W]    - last complete frame, slots 0..3
//            slot[2]      - slot index the next beat will be written to
//            locked       - high while frame alignment is held
//            frame_valid  - 1-cycle pulse: y0..y3 updated this cycle
//            sync_err     - 1-cycle pulse: framing violation on previous beat
// Revision : 1.0  initial release
// ============================================================================
module demux1x4_tdm #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         fsync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         frame_valid,
    output logic         sync_err
);

    localparam logic [0:0] c_HUNT = 1'b0;
    localparam logic [0:0] c_LOCK = 1'b1;

    logic [0:0]   r_state;
    logic [1:0]   r_slot;
    // Slot 3 needs no shadow entry: it is published straight from din.
    logic [W-1:0] r_shadow0;
    logic [W-1:0] r_shadow1;
    logic [W-1:0] r_shadow2;
    logic [W-1:0] r_y0;
    logic [W-1:0] r_y1;
    logic [W-1:0] r_y2;
    logic [W-1:0] r_y3;
    logic         r_frame_valid;
    logic         r_sync_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_HUNT;
            r_slot        <= 2'd0;
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_shadow2     <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            // Both status flags are single-cycle pulses.
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    c_HUNT: begin
                        // Non-sync beats are dropped silently while hunting.
                        if (fsync) begin
                            r_shadow0 <= din;
                            r_slot    <= 2'd1;
                            r_state   <= c_LOCK;
                        end
                    end
                    default: begin
                        if (r_slot == 2'd0) begin
                            if (fsync) begin
                                r_shadow0 <= din;
                                r_slot    <= 2'd1;
                            end else begin
                                // Expected a marker and none came: alignment lost.
                                r_sync_err <= 1'b1;
                                r_state    <= c_HUNT;
                                r_slot     <= 2'd0;
                            end
                        end else if (fsync) begin
                            // Early marker: abandon the partial frame and
                            // restart it with this beat as slot 0.
                            r_sync_err <= 1'b1;
                            r_shadow0  <= din;
                            r_slot     <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd1:    r_shadow1 <= din;
                                2'd2:    r_shadow2 <= din;
                                default: begin
                                    r_y0          <= r_shadow0;
                                    r_y1          <= r_shadow1;
                                    r_y2          <= r_shadow2;
                                    r_y3          <= din;
                                    r_frame_valid <= 1'b1;
                                end
                            endcase
                            // 3 + 1 wraps to 0 in two bits.
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign slot        = r_slot;
    assign locked      = (r_state == c_LOCK);
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_demux1x4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1x4_tdm
// Purpose  : Self-checking bench for demux1x4_tdm. A W=4 and a W=1 instance
//            share one beat stream; expected frames are queued as the
//            stimulus is driven and popped when frame_valid is seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux1x4_tdm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       fsync = 1'b0;

    logic [3:0] y0, y1, y2, y3;
    logic [1:0] slot;
    logic       locked, frame_valid, sync_err;

    logic       b_y0, b_y1, b_y2, b_y3;
    logic [1:0] b_slot;
    logic       b_locked, b_frame_valid, b_sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  exp1_q[$];
    logic [15:0] exp_y;
    logic [3:0]  exp_b;

    demux1x4_tdm #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .slot(slot), .locked(locked),
        .frame_valid(frame_valid), .sync_err(sync_err)
    );

    demux1x4_tdm #(.W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din[0:0]), .din_valid(din_valid), .fsync(fsync),
        .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3), .slot(b_slot), .locked(b_locked),
        .frame_valid(b_frame_valid), .sync_err(b_sync_err)
    );

    always #5 clk = ~clk;

    // Status of the W=4 instance: {slot, locked, frame_valid, sync_err}.
    wire [4:0]  st = {slot, locked, frame_valid, sync_err};
    wire [15:0] yv = {y3, y2, y1, y0};

    task automatic beat(input logic fs, input logic [3:0] d);
        @(negedge clk);
        din_valid = 1'b1;
        fsync     = fs;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        fsync     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({yv, st} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got y=%h st=%b expected all zero", yv, st);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({yv, st} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_release: got y=%h st=%b expected all zero", yv, st);
        end
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 4'hD);
        n_tests++;
        if (st !== 5'b01_1_0_0) begin n_fail++; $display("FAIL b2b_beat0: st=%b expected 01100", st); end
        beat(1'b0, 4'h1);
        n_tests++;
        if (st !== 5'b10_1_0_0) begin n_fail++; $display("FAIL b2b_beat1: st=%b expected 10100", st); end
        beat(1'b0, 4'h0);
        n_tests++;
        if (st !== 5'b11_1_0_0) begin n_fail++; $display("FAIL b2b_beat2: st=%b expected 11100", st); end
        exp_q.push_back(16'h101D);
        beat(1'b0, 4'h1);
        n_tests++;
        if (st !== 5'b00_1_1_0) begin n_fail++; $display("FAIL b2b_beat3: st=%b expected 00110", st); end
        n_tests++;
        if (!frame_valid || exp_q.size() == 0) begin
            n_fail++; $display("FAIL b2b_publish: frame_valid=%b queued=%0d", frame_valid, exp_q.size());
        end else begin
            exp_y = exp_q.pop_front();
            if (yv !== exp_y) begin n_fail++; $display("FAIL b2b_y: got %h expected %h", yv, exp_y); end
        end
        gap(1);
        n_tests++;
        if (st !== 5'b00_1_0_0) begin n_fail++; $display("FAIL b2b_pulse_end: st=%b expected 00100", st); end
    endtask

    task automatic test_gaps();
        logic [3:0] d[4];
        d[0] = 4'hD; d[1] = 4'h1; d[2] = 4'h0; d[3] = 4'h1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(16'h101D);
            beat(k == 0, d[k]);
            if (k == 3) begin
                n_tests++;
                if (!frame_valid || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL gap_publish: frame_valid=%b queued=%0d", frame_valid, exp_q.size());
                end else begin
                    exp_y = exp_q.pop_front();
                    if (yv !== exp_y || slot !== 2'd0) begin
                        n_fail++; $display("FAIL gap_y: got %h slot %0d expected %h slot 0", yv, slot, exp_y);
                    end
                end
            end
            gap(3);
            n_tests++;
            if (st !== {2'(k + 1), 3'b1_0_0}) begin
                n_fail++; $display("FAIL gap_hold_%0d: st=%b expected slot %0d locked, no pulses", k, st, (k + 1) % 4);
            end
        end
    endtask

    task automatic test_early_sync();
        beat(1'b1, 4'h5);
        beat(1'b0, 4'h6);
        n_tests++;
        if (st !== 5'b10_1_0_0) begin n_fail++; $display("FAIL early_pre: st=%b expected 10100", st); end
        beat(1'b1, 4'hA);
        n_tests++;
        if (st !== 5'b01_1_0_1 || yv !== 16'h101D) begin
            n_fail++; $display("FAIL early_err: st=%b y=%h expected 01101 y=101d", st, yv);
        end
        gap(1);
        n_tests++;
        if (st !== 5'b01_1_0_0) begin n_fail++; $display("FAIL early_err_end: st=%b expected 01100", st); end
        beat(1'b0, 4'hB);
        beat(1'b0, 4'hC);
        exp_q.push_back(16'hECBA);
        beat(1'b0, 4'hE);
        n_tests++;
        if (!frame_valid || exp_q.size() == 0) begin
            n_fail++; $display("FAIL early_publish: frame_valid=%b queued=%0d", frame_valid, exp_q.size());
        end else begin
            exp_y = exp_q.pop_front();
            if (yv !== exp_y || st !== 5'b00_1_1_0) begin
                n_fail++; $display("FAIL early_y: got %h st=%b expected %h st=00110", yv, st, exp_y);
            end
        end
    endtask

    task automatic test_lost_sync();
        beat(1'b0, 4'h7);
        n_tests++;
        if (st !== 5'b00_0_0_1) begin n_fail++; $display("FAIL lost_err: st=%b expected 00001", st); end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 4'(i + 1));
            n_tests++;
            if (st !== 5'b00_0_0_0 || yv !== 16'hECBA) begin
                n_fail++; $display("FAIL lost_hunt_%0d: st=%b y=%h expected 00000 y=ecba", i, st, yv);
            end
        end
        beat(1'b1, 4'h3);
        n_tests++;
        if (st !== 5'b01_1_0_0) begin n_fail++; $display("FAIL lost_relock: st=%b expected 01100", st); end
    endtask

    task automatic test_mid_reset();
        beat(1'b0, 4'h4);
        n_tests++;
        if (st !== 5'b10_1_0_0) begin n_fail++; $display("FAIL mrst_pre: st=%b expected 10100", st); end
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_tests++;
        if ({yv, st} !== 21'd0) begin
            n_fail++; $display("FAIL mrst_async: got y=%h st=%b expected all zero", yv, st);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            beat(1'b0, 4'h5);
            n_tests++;
            if (st !== 5'b00_0_0_0 || yv !== 16'h0000) begin
                n_fail++; $display("FAIL mrst_hunt_%0d: st=%b y=%h expected 00000 y=0000", i, st, yv);
            end
        end
        beat(1'b1, 4'h9);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h7);
        exp_q.push_back(16'h6789);
        beat(1'b0, 4'h6);
        n_tests++;
        if (!frame_valid || exp_q.size() == 0) begin
            n_fail++; $display("FAIL mrst_publish: frame_valid=%b queued=%0d", frame_valid, exp_q.size());
        end else begin
            exp_y = exp_q.pop_front();
            if (yv !== exp_y || st !== 5'b00_1_1_0) begin
                n_fail++; $display("FAIL mrst_y: got %h st=%b expected %h st=00110", yv, st, exp_y);
            end
        end
    endtask

    // W=1 instance: frame value f is read as y3..y0, so slot k carries f[k].
    task automatic test_w1();
        logic [3:0] frames[3];
        logic [3:0] f;
        frames[0] = 4'b1101; frames[1] = 4'b0010; frames[2] = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            f = frames[n];
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp1_q.push_back(f);
                beat(k == 0, {3'b000, f[k]});
                n_tests++;
                if (k != 3) begin
                    if (b_frame_valid !== 1'b0 || b_locked !== 1'b1) begin
                        n_fail++; $display("FAIL w1_f%0d_s%0d: frame_valid=%b locked=%b expected 0 1", n, k, b_frame_valid, b_locked);
                    end
                end else if (!b_frame_valid || exp1_q.size() == 0) begin
                    n_fail++; $display("FAIL w1_f%0d_publish: frame_valid=%b queued=%0d", n, b_frame_valid, exp1_q.size());
                end else begin
                    exp_b = exp1_q.pop_front();
                    if ({b_y3, b_y2, b_y1, b_y0} !== exp_b || b_slot !== 2'd0) begin
                        n_fail++; $display("FAIL w1_f%0d_y: got %b slot %0d expected %b slot 0", n, {b_y3, b_y2, b_y1, b_y0}, b_slot, exp_b);
                    end
                end
            end
        end
        gap(1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_early_sync();
        test_lost_sync();
        test_mid_reset();
        test_w1();
        n_tests++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d and %0d frames never published", exp_q.size(), exp1_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
